// File: rtl/expr_sched.sv
// expr_sched: two-requester job scheduler in front of a single shared compute
// unit. A round-robin arbiter accepts one job at a time, restarts the compute
// unit for one cycle, waits (bounded) for its result and holds the response
// until the consumer takes it.
module expr_sched #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = WIDTH + 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req0_valid,
    input  logic [WIDTH-1:0]    req0_a,
    input  logic [WIDTH-1:0]    req0_b,
    output logic                req0_ready,

    input  logic                req1_valid,
    input  logic [WIDTH-1:0]    req1_a,
    input  logic [WIDTH-1:0]    req1_b,
    output logic                req1_ready,

    output logic                rsp_valid,
    output logic                rsp_id,
    output logic [OP_WIDTH-1:0] rsp_data,
    output logic                rsp_err,
    input  logic                rsp_ready,

    output logic                cu_rst_n,
    output logic [WIDTH-1:0]    cu_a,
    output logic [WIDTH-1:0]    cu_b,
    input  logic [OP_WIDTH-1:0] cu_result,
    input  logic                cu_ready,

    output logic [15:0]         jobs_done
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        last_served;
    logic [15:0] done_cnt;
    logic        grant0;
    logic        grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign jobs_done  = done_cnt;

    // Round-robin grant, only offered while idle; on a tie the requester
    // that was not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && (!req1_valid || last_served)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    // Job sequencer: accept, pulse the compute-unit restart, wait with a
    // timeout, then hold the response until it is handshaken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            last_served <= 1'b1;
            done_cnt    <= 16'd0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            cu_rst_n    <= 1'b0;
            cu_a        <= '0;
            cu_b        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cu_rst_n <= !(grant0 || grant1);
                    if (grant0 || grant1) begin
                        cu_a        <= grant1 ? req1_a : req0_a;
                        cu_b        <= grant1 ? req1_b : req0_b;
                        rsp_id      <= grant1;
                        last_served <= grant1;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cu_rst_n <= 1'b1;
                    wait_cnt <= 8'd1;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (cu_ready) begin
                        rsp_data  <= cu_result;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= done_cnt + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_expr_sched.sv
// tb_expr_sched: randomized scoreboard bench for expr_sched with a behavioural
// compute-unit model and a reference model of arbitration, results, timeouts
// and the completed-job counter.
module tb_expr_sched;

    localparam int WIDTH    = 32;
    localparam int OP_WIDTH = WIDTH + 4;
    localparam int TIMEOUT  = 16;

    typedef struct {
        logic                id;
        logic [OP_WIDTH-1:0] data;
        logic                err;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                req0_valid, req1_valid;
    logic [WIDTH-1:0]    req0_a, req0_b, req1_a, req1_b;
    logic                req0_ready, req1_ready;
    logic                rsp_valid, rsp_id, rsp_err, rsp_ready;
    logic [OP_WIDTH-1:0] rsp_data;
    logic                cu_rst_n;
    logic [WIDTH-1:0]    cu_a, cu_b;
    logic [OP_WIDTH-1:0] cu_result = '0;
    logic                cu_ready = 1'b0;
    logic [15:0]         jobs_done;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [15:0] jobs_exp = 16'd0;
    logic        last_exp = 1'b1;
    int          cu_delay = 8;
    bit          cu_stall = 1'b0;
    int          cu_cnt = 0;

    expr_sched #(.WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready),
        .cu_rst_n(cu_rst_n), .cu_a(cu_a), .cu_b(cu_b), .cu_result(cu_result), .cu_ready(cu_ready),
        .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    // Compute-unit result formula: 8*(a/2+b)+4*(a-b/2), truncated to OP_WIDTH.
    function automatic logic [OP_WIDTH-1:0] ref_result(input logic [WIDTH-1:0] a,
                                                        input logic [WIDTH-1:0] b);
        logic [63:0] av, bv, r;
        av = {32'd0, a};
        bv = {32'd0, b};
        r  = 64'd8 * (av / 64'd2 + bv) + 64'd4 * (av - bv / 64'd2);
        return r[OP_WIDTH-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compute unit: result and ready appear cu_delay cycles after restart release.
    always @(posedge clk) begin
        if (!cu_rst_n) begin
            cu_cnt   <= 0;
            cu_ready <= 1'b0;
        end else begin
            cu_cnt <= cu_cnt + 1;
            if (!cu_stall && (cu_cnt + 1 >= cu_delay)) begin
                cu_ready  <= 1'b1;
                cu_result <= ref_result(cu_a, cu_b);
            end
        end
    end

    // Monitor: scoreboard compare on every response handshake, stability of a
    // pending response, and the length of each compute-unit restart pulse.
    logic        held = 1'b0;
    logic [37:0] held_vec;
    int          low_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held    = 1'b0;
            low_cnt = 100;
        end else begin
            if (!cu_rst_n) begin
                low_cnt++;
            end else begin
                if (low_cnt != 0 && low_cnt < 100) checkOutput("cu_rst_pulse_len", low_cnt, 1);
                low_cnt = 0;
            end
            if (rsp_valid) begin
                if (!held) begin
                    held     = 1'b1;
                    held_vec = {rsp_id, rsp_err, rsp_data};
                end else begin
                    checkOutput("rsp_stable", {rsp_id, rsp_err, rsp_data}, held_vec);
                end
                if (rsp_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_rsp", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("rsp_id", rsp_id, e.id);
                        checkOutput("rsp_err", rsp_err, e.err);
                        checkOutput("rsp_data", rsp_data, e.data);
                        checkOutput("jobs_done", jobs_done, jobs_exp);
                        jobs_exp = jobs_exp + 16'd1;
                    end
                end
            end
        end
    end

    // Predict the winner and response, present the request, and wait for its
    // acceptance; the DUT is idle whenever this is called so acceptance is immediate.
    task automatic applyStimulus(input bit v0, input bit v1,
                                 input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                                 input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                                 input int delay, input bit stall, output int exp_lat);
        exp_t e;
        bit   w;
        bit   got = 1'b0;
        bit   acc = 1'b0;
        int   waited = 0;
        w     = (v0 && v1) ? !last_exp : v1;
        e.id  = w;
        e.err = stall || (delay >= TIMEOUT);
        e.data = e.err ? '0 : (w ? ref_result(a1, b1) : ref_result(a0, b0));
        // Result is visible in WAIT cycle delay+1; otherwise the timeout ends WAIT cycle TIMEOUT.
        exp_lat = e.err ? TIMEOUT + 1 : delay + 2;
        exp_q.push_back(e);
        cu_delay = delay;
        cu_stall = stall;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                got = 1'b1;
                acc = req1_valid && req1_ready;
                checkOutput("single_grant", {31'd0, req0_ready & req1_ready}, 0);
                break;
            end
            waited++;
        end
        checkOutput("accept_latency", waited, 0);
        if (got) checkOutput("grant_id", acc, w);
        last_exp = w;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Drive noise on the requesters while busy, hold rsp_ready low for
    // 'hold' response cycles, and wait until the scoreboard drains.
    task automatic finish_job(input int hold, input int exp_lat);
        bit done = 1'b0;
        bit seen = 1'b0;
        int lat  = 0;
        int h    = hold;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            if (!seen) lat++;
            if (rsp_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    checkOutput("rsp_latency", lat, exp_lat);
                end
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                if (h == 0) rsp_ready = 1'b1;
                else h--;
            end else begin
                req0_valid = 1'($urandom_range(0, 1));
                req1_valid = 1'($urandom_range(0, 1));
                req0_a = $urandom; req0_b = $urandom;
                req1_a = $urandom; req1_b = $urandom;
            end
            #1;
            checkOutput("ready_while_busy", {req0_ready, req1_ready}, 2'b00);
        end
        rsp_ready  = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!done) begin
            checkOutput("job_timeout", 1, 0);
            exp_q.delete();
        end
    endtask

    task automatic run_job(input bit v0, input bit v1,
                           input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                           input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                           input int delay, input bit stall, input int hold);
        int lat;
        applyStimulus(v0, v1, a0, b0, a1, b1, delay, stall, lat);
        finish_job(hold, lat);
    endtask

    task automatic check_reset_values();
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_id", rsp_id, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        checkOutput("rst_rsp_err", rsp_err, 0);
        checkOutput("rst_jobs_done", jobs_done, 0);
        checkOutput("rst_cu_rst_n", cu_rst_n, 0);
        checkOutput("rst_cu_a", cu_a, 0);
        checkOutput("rst_cu_b", cu_b, 0);
    endtask

    // Directed scenarios, mid-job reset, randomized jobs, then counter wrap.
    initial begin
        int pat;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_job(1, 0, 32'd8, 32'd4, 32'd0, 32'd0, 8, 0, 0);
        run_job(1, 0, 32'd5, 32'd9, 32'd0, 32'd0, 8, 1, 0);
        run_job(0, 1, 32'd0, 32'd0, 32'd100, 32'd7, TIMEOUT - 1, 0, 1);
        run_job(0, 1, 32'd0, 32'd0, 32'd100, 32'd7, TIMEOUT, 0, 0);
        run_job(1, 0, 32'd77, 32'd33, 32'd0, 32'd0, 3, 0, 5);

        // Reset while the compute unit is being waited on.
        begin
            int lat;
            applyStimulus(1, 0, 32'd11, 32'd22, 32'd0, 32'd0, 8, 1, lat);
            repeat (4) @(posedge clk);
            #1;
            rst_n = 1'b0;
            @(negedge clk);
            check_reset_values();
            exp_q.delete();
            jobs_exp = 16'd0;
            last_exp = 1'b1;
            @(posedge clk); #1;
            rst_n = 1'b1;
            applyStimulus(1, 1, 32'd8, 32'd4, 32'd2, 32'd2, 8, 0, lat);
            finish_job(0, lat);
            run_job(1, 1, 32'd8, 32'd4, 32'd2, 32'd2, 8, 0, 0);
        end

        for (int i = 0; i < 40; i++) begin
            pat = $urandom_range(1, 3);
            run_job(pat[0], pat[1], $urandom, $urandom, $urandom, $urandom,
                    $urandom_range(1, 20), ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
        end

        // Counter wrap: preload just below the top and complete two jobs.
        force dut.done_cnt = 16'hFFFE;
        jobs_exp = 16'hFFFE;
        @(negedge clk);
        release dut.done_cnt;
        @(posedge clk); #1;
        checkOutput("jobs_done_preload", jobs_done, 16'hFFFE);
        run_job(1, 0, $urandom, $urandom, 32'd0, 32'd0, 5, 0, 0);
        run_job(0, 1, 32'd0, 32'd0, $urandom, $urandom, 5, 0, 0);
        @(negedge clk);
        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("jobs_done_final", jobs_done, jobs_exp);
        checkOutput("jobs_done_wrapped", jobs_done, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
